// File: rtl/instr_fetch_pkg.sv
// Shared state encoding, constants and helpers for the instruction fetch sequencer.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      S_ISSUE,
      S_FETCH,
      S_DRAIN,
      S_HOLD
   } fetch_state_t;

   localparam int          WORD_BYTES = 4;
   localparam int          ALIGN_BITS = $clog2(WORD_BYTES);
   localparam logic [31:0] INSTR_NOP  = 32'h0;

   function automatic logic isWordAligned(input logic [ALIGN_BITS-1:0] lowBits);
      return lowBits == '0;
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: PC -> memory req/ack -> decode valid/ready, with redirect.
// Optional build macro INSTR_FETCH_ALIGN_CHECK_EN adds a sticky fetchFault on misaligned PCs.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pcAddress,
   output logic              count,
   output logic              shouldUseNewPC,
   output logic [ADDR_W-1:0] newPC,
   output logic [ADDR_W-1:0] memAddress,
   output logic              memRequest,
   input  logic              memAck,
   input  logic [DATA_W-1:0] memReadData,
   output logic [DATA_W-1:0] instruction,
   output logic [ADDR_W-1:0] instructionPC,
   output logic              instructionValid,
   input  logic              instructionReady,
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   output logic              fetchFault,
`endif
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirectPC
);

   fetch_state_t state, nextState;
   logic         issueOk;
   logic         issueLatch;
   logic         fetchAccept;
   logic         holdRelease;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   assign issueOk = isWordAligned(pcAddress[ALIGN_BITS-1:0]);

   // Sticky until the next redirect, which is the only way software can move the PC.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         fetchFault <= 1'b0;
      else if (redirect)
         fetchFault <= 1'b0;
      else if (state == S_ISSUE && !issueOk)
         fetchFault <= 1'b1;
   end
`else
   assign issueOk = 1'b1;
`endif

   assign shouldUseNewPC = redirect;
   assign newPC          = redirectPC;
   // A redirect coinciding with an ack still yields a single pulse; the PC takes newPC.
   assign count          = redirect | (state == S_FETCH && memAck);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= S_ISSUE;
      else
         state <= nextState;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      nextState   = state;
      memRequest  = 1'b0;
      issueLatch  = 1'b0;
      fetchAccept = 1'b0;
      holdRelease = 1'b0;
      unique case (state)
         S_ISSUE: begin
            if (!redirect && issueOk) begin
               issueLatch = 1'b1;
               nextState  = S_FETCH;
            end
         end
         S_FETCH: begin
            memRequest = 1'b1;
            if (memAck) begin
               fetchAccept = !redirect;
               nextState   = redirect ? S_ISSUE : S_HOLD;
            end else if (redirect) begin
               nextState = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // The request cannot be withdrawn, so wait out the ack and discard the data.
            memRequest = 1'b1;
            if (memAck)
               nextState = S_ISSUE;
         end
         S_HOLD: begin
            if (instructionReady || redirect) begin
               holdRelease = 1'b1;
               nextState   = S_ISSUE;
            end
         end
         default: nextState = S_ISSUE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         memAddress       <= '0;
         instruction      <= DATA_W'(INSTR_NOP);
         instructionPC    <= '0;
         instructionValid <= 1'b0;
      end else begin
         if (issueLatch)
            memAddress <= pcAddress;
         if (fetchAccept) begin
            instruction      <= memReadData;
            instructionPC    <= memAddress;
            instructionValid <= 1'b1;
         end else if (holdRelease) begin
            instructionValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a PC-block model drives pcAddress, a scoreboard checks delivered words.
module tb_instr_fetch;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic [ADDR_W-1:0] pcAddress;
   logic              count;
   logic              shouldUseNewPC;
   logic [ADDR_W-1:0] newPC;
   logic [ADDR_W-1:0] memAddress;
   logic              memRequest;
   logic              memAck;
   logic [DATA_W-1:0] memReadData;
   logic [DATA_W-1:0] instruction;
   logic [ADDR_W-1:0] instructionPC;
   logic              instructionValid;
   logic              instructionReady;
   logic              redirect;
   logic [ADDR_W-1:0] redirectPC;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
   logic              fetchFault;
`endif

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [ADDR_W-1:0] pc;
   } sbEntry_t;

   sbEntry_t          sb[$];
   int                nCompared   = 0;
   int                nMismatched = 0;
   logic [ADDR_W-1:0] pcInit;
   logic [ADDR_W-1:0] pcReg;

   always #5 clk = ~clk;

   instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .pcAddress        (pcAddress),
      .count            (count),
      .shouldUseNewPC   (shouldUseNewPC),
      .newPC            (newPC),
      .memAddress       (memAddress),
      .memRequest       (memRequest),
      .memAck           (memAck),
      .memReadData      (memReadData),
      .instruction      (instruction),
      .instructionPC    (instructionPC),
      .instructionValid (instructionValid),
      .instructionReady (instructionReady),
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
      .fetchFault       (fetchFault),
`endif
      .redirect         (redirect),
      .redirectPC       (redirectPC)
   );

   // PC block model: load on redirect, advance by one word on count.
   always @(posedge clk or negedge rst) begin
      if (!rst)
         pcReg <= pcInit;
      else if (shouldUseNewPC)
         pcReg <= newPC;
      else if (count)
         pcReg <= pcReg + 32'd4;
   end
   assign pcAddress = pcReg;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      nCompared++;
      assert (observed === expected) else begin
         nMismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard consumer: every word decode accepts must match the oldest expected fetch.
   always begin
      @(negedge clk);
      #2;
      if (rst === 1'b1 && instructionValid === 1'b1 && instructionReady === 1'b1) begin
         check("sb has entry", sb.size() > 0, 1'b1);
         if (sb.size() > 0) begin
            sbEntry_t e;
            e = sb.pop_front();
            check("sb instruction", instruction, e.data);
            check("sb instructionPC", instructionPC, e.pc);
         end
      end
   end

   task automatic awaitRequest(input string tag, output int gap);
      gap = 0;
      while (memRequest !== 1'b1 && gap < 8) begin
         @(negedge clk);
         #1;
         gap++;
      end
      check({tag, " request seen"}, memRequest, 1'b1);
   endtask

   task automatic fetch(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                        input int ackDelay, output int gap);
      memAck = 1'b0;
      awaitRequest("fetch", gap);
      check("fetch memAddress", memAddress, addr);
      for (int i = 0; i < ackDelay; i++) begin
         check("wait count", count, 1'b0);
         @(negedge clk);
         #1;
         check("wait memRequest held", memRequest, 1'b1);
         check("wait memAddress held", memAddress, addr);
      end
      memAck      = 1'b1;
      memReadData = data;
      #1;
      check("ack count", count, 1'b1);
      sb.push_back('{data, addr});
      @(negedge clk);
      memAck = 1'b0;
      #1;
      check("hold valid", instructionValid, 1'b1);
      check("hold memRequest", memRequest, 1'b0);
      check("hold count", count, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int gap;
      rst              = 1'b0;
      pcInit           = 32'h400;
      memAck           = 1'b1;
      memReadData      = 32'h2408000A;
      instructionReady = 1'b1;
      redirect         = 1'b0;
      redirectPC       = '0;

      // Reset state
      @(negedge clk);
      #1;
      check("rst memRequest", memRequest, 1'b0);
      check("rst memAddress", memAddress, 32'h0);
      check("rst instruction", instruction, 32'h0);
      check("rst instructionPC", instructionPC, 32'h0);
      check("rst instructionValid", instructionValid, 1'b0);
      check("rst count", count, 1'b0);
      check("rst shouldUseNewPC", shouldUseNewPC, 1'b0);
      rst = 1'b1;

      // 1: zero-wait sequential fetches, one instruction per three cycles
      fetch(32'h400, 32'h2408000A, 0, gap);
      check("first issue gap", gap, 1);
      fetch(32'h404, 32'h2409000B, 0, gap);
      check("steady issue gap 404", gap, 2);
      fetch(32'h408, 32'h240A000C, 0, gap);
      check("steady issue gap 408", gap, 2);

      // 2: decode back-pressure holds the word and stalls the PC
      @(negedge clk);
      instructionReady = 1'b0;
      fetch(32'h40C, 32'h8C220004, 0, gap);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("stall valid held", instructionValid, 1'b1);
         check("stall memRequest", memRequest, 1'b0);
         check("stall count", count, 1'b0);
         check("stall instruction", instruction, 32'h8C220004);
      end
      instructionReady = 1'b1;

      // 3: ack delayed three cycles
      fetch(32'h410, 32'hAC230008, 3, gap);

      // 4: redirect while a request is outstanding
      memAck = 1'b0;
      awaitRequest("redir", gap);
      check("redir memAddress", memAddress, 32'h414);
      redirect   = 1'b1;
      redirectPC = 32'h800;
      #1;
      check("redir shouldUseNewPC", shouldUseNewPC, 1'b1);
      check("redir newPC", newPC, 32'h800);
      check("redir count", count, 1'b1);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      check("drain count", count, 1'b0);
      check("drain memRequest", memRequest, 1'b1);
      check("drain memAddress", memAddress, 32'h414);
      check("drain valid", instructionValid, 1'b0);
      @(negedge clk);
      #1;
      check("drain memRequest 2", memRequest, 1'b1);
      memAck      = 1'b1;
      memReadData = 32'hDEADBEEF;
      #1;
      check("drain ack count", count, 1'b0);
      @(negedge clk);
      memAck = 1'b0;
      #1;
      check("post-drain valid", instructionValid, 1'b0);
      check("post-drain memRequest", memRequest, 1'b0);
      fetch(32'h800, 32'h00851020, 0, gap);

      // 5: redirect coincident with ack
      memAck = 1'b0;
      awaitRequest("coinc", gap);
      check("coinc memAddress", memAddress, 32'h804);
      memAck      = 1'b1;
      memReadData = 32'h0BADF00D;
      redirect    = 1'b1;
      redirectPC  = 32'hC00;
      #1;
      check("coinc count", count, 1'b1);
      check("coinc shouldUseNewPC", shouldUseNewPC, 1'b1);
      @(negedge clk);
      memAck   = 1'b0;
      redirect = 1'b0;
      #1;
      check("coinc count after", count, 1'b0);
      check("coinc valid", instructionValid, 1'b0);
      check("coinc memRequest", memRequest, 1'b0);
      fetch(32'hC00, 32'h3C011234, 0, gap);

      // 6: asynchronous reset in the middle of a fetch
      memAck = 1'b0;
      awaitRequest("arst", gap);
      check("arst memAddress before", memAddress, 32'hC04);
      pcInit = 32'h200;
      memAck = 1'b1;
      rst    = 1'b0;
      #1;
      check("arst memRequest", memRequest, 1'b0);
      check("arst valid", instructionValid, 1'b0);
      check("arst count", count, 1'b0);
      check("arst memAddress", memAddress, 32'h0);
      check("arst instructionPC", instructionPC, 32'h0);
      @(negedge clk);
      memAck = 1'b0;
      rst    = 1'b1;
      fetch(32'h200, 32'h34210001, 0, gap);

      @(negedge clk);
      @(negedge clk);
      #3;
      check("sb drained", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Instruction fetch sequencer on the consumer side of the PC block. It reads pcAddress, issues word reads to instruction memory over a req/ack handshake, and presents fetched words to decode with a valid/ready handshake. It drives the PC controls back: count advances the PC on each accepted fetch; shouldUseNewPC/newPC load it on a redirect.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, instruction width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
pcAddress  in  ADDR_W  current PC from PC block
count  out  1  advance PC by 4 at next edge
shouldUseNewPC  out  1  load newPC at next edge
newPC  out  ADDR_W  redirect target to PC block
memAddress  out  ADDR_W  fetch address, stable while memRequest=1
memRequest  out  1  read request
memAck  in  1  transfer completes on edge where memRequest&memAck
memReadData  in  DATA_W  read data, valid when memAck=1
instruction  out  DATA_W  fetched word
instructionPC  out  ADDR_W  address of instruction
instructionValid  out  1  instruction/instructionPC valid
instructionReady  in  1  decode accepts when valid&ready
redirect  in  1  one-cycle redirect strobe
redirectPC  in  ADDR_W  redirect target

Behaviour:
- Reset (rst=0, async): state S_ISSUE; memAddress=0, memRequest=0, instruction=0, instructionPC=0, instructionValid=0; count=0, shouldUseNewPC=0.
- States: S_ISSUE, S_FETCH, S_DRAIN, S_HOLD.
- S_ISSUE: memRequest=0. Latch memAddress<=pcAddress, then go to S_FETCH. Redirect here: stay in S_ISSUE and re-latch next cycle.
- S_FETCH: memRequest=1; memAddress held stable.
  - ack&!redirect: instruction<=memReadData, instructionPC<=memAddress, instructionValid<=1, count=1, go to S_HOLD.
  - ack&redirect: data dropped, go to S_ISSUE.
  - !ack&redirect: go to S_DRAIN.
- S_DRAIN: memRequest=1 until ack. A request is never withdrawn. On ack, data is dropped and state goes to S_ISSUE. No count from the ack.
- S_HOLD: instructionValid=1, no request. instructionReady=1 or redirect: instructionValid<=0, go to S_ISSUE.
- count = redirect | (S_FETCH & memAck). It is combinational and single-cycle per event. Redirect plus ack in the same cycle still gives one pulse; PC takes newPC.
- shouldUseNewPC=redirect and newPC=redirectPC are combinational pass-through in any state.
- Latency: S_ISSUE latch → memRequest next cycle → instructionValid the cycle after ack. Zero-wait memory gives 1 instruction per 3 cycles.
- No instruction is ever presented from a fetch that was outstanding at redirect.

Optional Feature:
INSTR_FETCH_ALIGN_CHECK_EN:
- Defined: adds output fetchFault (1 bit, reset 0).
  - In S_ISSUE with pcAddress[1:0]!=0: no request, fetchFault<=1 (sticky), stay in S_ISSUE, count=0.
  - Cleared on the edge where redirect=1.
- Undefined: port absent; low address bits ignored, fetch issued.

Decomposition:
- Package instr_fetch_pkg:
  - state enum fetch_state_t {S_ISSUE, S_FETCH, S_DRAIN, S_HOLD}
  - WORD_BYTES=4
  - INSTR_NOP=32'h0
- No sub-module; single FSM plus output registers.

Test Plan:
1. Release rst, pcAddress from PC (0x400), memAck=1, memReadData=0x2408000A, instructionReady=1 → memAddress=0x400, count one pulse, instruction=0x2408000A, instructionPC=0x400; next fetches at 0x404, 0x408.
2. instructionReady=0 after first fetch → instructionValid held, memRequest=0, count=0 until ready; then fetch 0x404.
3. memAck delayed 3 cycles → memRequest and memAddress=0x404 stable all 3 cycles; count only on ack cycle.
4. redirect=1, redirectPC=0x800 while request to 0x404 is outstanding → shouldUseNewPC=1, newPC=0x800, count=1 one cycle; request held until ack, data dropped (instructionValid=0); next memAddress=0x800.
5. redirect coincident with memAck → exactly one count pulse, no instructionValid, next memAddress=0x800.
6. rst=0 mid-S_FETCH → memRequest, instructionValid, count drop immediately. After release, fetch restarts from pcAddress.
